// File: rtl/mul_shift_add.sv
// Sequential signed 16x16 multiplier: magnitudes are multiplied by right-shift/add
// through the shared external adder, then the sign is restored in a final FIX cycle.
module mul_shift_add #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_carry,
  output logic [1:0]         state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Unsigned magnitudes; |-2^(W-1)| wraps to 2^(W-1), which is exactly right unsigned.
  always_comb begin
    mag_a = op_a[WIDTH-1] ? -op_a : op_a;
    mag_b = op_b[WIDTH-1] ? -op_b : op_b;
  end

  // Adder operands come from registered state only, keeping the loop through the adder one cycle.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state == RUN) begin
      add_a = acc[2*WIDTH-1:WIDTH];
      add_b = acc[0] ? mcand : '0;
    end
  end

  assign busy      = (state == RUN) || (state == FIX);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= mag_a;
            acc   <= {{WIDTH{1'b0}}, mag_b};
            neg   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= {add_carry, add_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          product <= neg ? -acc : acc;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_shift_add.sv
// Bench for mul_shift_add: provides the adder, a cycle-level reference model with
// an expected-product queue, a per-cycle compare process, and directed vectors.
module tb_mul_shift_add;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        add_carry;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  mul_shift_add #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_carry(add_carry),
    .state_dbg(state_dbg)
  );

  // the shared CPU adder
  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: m_left = edges remaining until the result appears
  logic [31:0] exp_q[$];
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_prod = '0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_prod = '0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_prod = exp_q.pop_front();
        end
      end else if (start) begin
        int sa, sb;
        sa = int'($signed(op_a));
        sb = int'($signed(op_b));
        m_left = 17;
        m_a = op_a;
        m_b = op_b;
        exp_q.push_back(32'(sa * sb));
      end
    end
  end

  // per-cycle compare process
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("product", product, m_prod);
      if (m_left >= 2) begin
        int i;
        logic [15:0] mag_a, mag_b;
        i = 17 - m_left;
        mag_a = m_a[15] ? 16'(0 - int'(m_a)) : m_a;
        mag_b = m_b[15] ? 16'(0 - int'(m_b)) : m_b;
        chk("add_b_run", 32'(add_b), 32'(mag_b[i] ? mag_a : 16'd0));
      end else begin
        chk("add_a_idle", 32'(add_a), 32'd0);
        chk("add_b_idle", 32'(add_b), 32'd0);
      end
    end
    if (done) done_cnt++;
  end

  // driver: pulse start (from mid-cycle), wait for done, check latency and value
  task automatic mul_run(input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input string name);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 1'b0;
    op_a = a;
    op_b = b;
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      cyc++;
      if (k == 0) begin
        #2 start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(cyc), 32'd18);
    chk({name, "_product"}, product, exp);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    int d0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", product, 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #2;

    mul_run(16'h0002, 16'h0004, 32'h0000_0008, "2x4");
    mul_run(16'h0008, 16'hFFFD, 32'hFFFF_FFE8, "8xm3");
    mul_run(16'hFFFD, 16'hFFFD, 32'h0000_0009, "m3xm3");
    mul_run(16'h8000, 16'h8000, 32'h4000_0000, "minxmin");
    mul_run(16'h7FFF, 16'h8000, 32'hC000_8000, "maxxmin");
    mul_run(16'h0000, 16'h1234, 32'h0000_0000, "0x1234");
    mul_run(16'h1234, 16'h0000, 32'h0000_0000, "1234x0");
    mul_run(16'hFFFF, 16'h0001, 32'hFFFF_FFFF, "m1x1");

    // start mid-RUN is ignored, then back-to-back issue in the done cycle
    @(posedge clk);
    #2;
    d0 = done_cnt;
    op_a = 16'd3;
    op_b = 16'd5;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    op_a = 16'd7;
    op_b = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done("3x5");
    chk("3x5_product", product, 32'd15);
    mul_run(16'd7, 16'd7, 32'd49, "7x7_b2b");
    @(posedge clk);
    #2;
    chk("done_count", 32'(done_cnt - d0), 32'd2);

    // asynchronous reset in the middle of RUN
    op_a = 16'h1234;
    op_b = 16'h0011;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (8) @(posedge clk);
    d0 = done_cnt;
    #3 rst = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_product", product, 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    chk("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    mul_run(16'd2, 16'd4, 32'd8, "2x4_after_rst");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
